conv_encoder: RTL and testbench

Transmit-side counterpart of the Viterbi decoder chain. It drains bytes from the upstream fifo using the fifo's rd_en/dv read handshake. Each byte is serialised MSB-first through a K=7, rate-1/2 convolutional encoder. Each frame is terminated with K-1 zero tail bits, and output symbol pairs use a valid/ready handshake toward the channel model or decoder input.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_shift_reg.sv | 23 ++
 rtl/conv_encoder.sv | 132 +++++++++++++
 tb/tb_conv_encoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared K=7 rate-1/2 convolutional code definitions for the encoder and the decoder's
// branch-metric unit.
package conv_pkg;

   localparam int unsigned  K  = 7;
   localparam logic [K-1:0] G0 = 7'o171;
   localparam logic [K-1:0] G1 = 7'o133;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWaitDv,
      StData,
      StTail
   } enc_state_t;

   // Window is {b, sr}; sr[K-2] is the most recent previous bit.
   function automatic logic [1:0] conv_sym(input logic b, input logic [K-2:0] sr);
      logic [K-1:0] w;
      w = {b, sr};
      return {^(w & G0), ^(w & G1)};
   endfunction

endpackage

// File: rtl/conv_shift_reg.sv
// K-1 bit encoder history register; advancing shifts the new bit in at the top.
module conv_shift_reg
   import conv_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_adv,
   input  logic         i_bit,
   output logic [K-2:0] o_sr,
   output logic [K-2:0] o_sr_nxt
);

   assign o_sr_nxt = {i_bit, o_sr[K-2:1]};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sr <= '0;
      end else if (i_adv) begin
         o_sr <= o_sr_nxt;
      end
   end

endmodule

// File: rtl/conv_encoder.sv
// Reads fixed-length frames from a fifo, convolutionally encodes them MSB-first and appends
// K-1 zero tail bits; symbols leave through a valid/ready handshake.
module conv_encoder
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned FRAME_BYTES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_dv,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_rd_en,
   output logic [1:0]            o_sym,
   output logic                  o_sym_valid,
   input  logic                  i_sym_ready,
   output logic                  o_sof,
   output logic                  o_eof,
   output logic                  o_busy
);

   localparam int unsigned BitW  = $clog2(DATA_WIDTH) + 1;
   localparam int unsigned ByteW = $clog2(FRAME_BYTES) + 1;
   localparam int unsigned TailW = $clog2(K) + 1;

   localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_WIDTH - 1);
   localparam logic [ByteW-1:0] LastByte = ByteW'(FRAME_BYTES - 1);
   localparam logic [TailW-1:0] TailTop  = TailW'(K - 2);

   enc_state_t            state;
   logic [DATA_WIDTH-1:0] data_q;
   logic [BitW-1:0]       bit_cnt;
   logic [BitW-1:0]       nxt_idx;
   logic [ByteW-1:0]      byte_cnt;
   logic [TailW-1:0]      tail_cnt;
   logic                  accept;
   logic                  cur_bit;
   logic [K-2:0]          sr;
   logic [K-2:0]          sr_nxt;

   // Valid is only ever high in DATA or TAIL, so acceptance doubles as the shift strobe.
   assign accept  = o_sym_valid & i_sym_ready;
   assign nxt_idx = bit_cnt - 1'b1;
   assign cur_bit = (state == StData) ? data_q[bit_cnt[BitW-2:0]] : 1'b0;
   assign o_busy  = (state != StIdle);

   conv_shift_reg u_sr (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_adv    (accept),
      .i_bit    (cur_bit),
      .o_sr     (sr),
      .o_sr_nxt (sr_nxt)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= StIdle;
         data_q       <= '0;
         bit_cnt      <= '0;
         byte_cnt     <= '0;
         tail_cnt     <= '0;
         o_fifo_rd_en <= 1'b0;
         o_sym        <= '0;
         o_sym_valid  <= 1'b0;
         o_sof        <= 1'b0;
         o_eof        <= 1'b0;
      end else begin
         o_fifo_rd_en <= 1'b0;
         unique case (state)
            StIdle: begin
               if (i_en && !i_fifo_empty) begin
                  byte_cnt <= '0;
                  state    <= StReq;
               end
            end
            StReq: begin
               if (!i_fifo_empty) begin
                  o_fifo_rd_en <= 1'b1;
                  state        <= StWaitDv;
               end
            end
            StWaitDv: begin
               if (i_fifo_dv) begin
                  data_q      <= i_fifo_data;
                  bit_cnt     <= LastBit;
                  o_sym       <= conv_sym(i_fifo_data[DATA_WIDTH-1], sr);
                  o_sym_valid <= 1'b1;
                  o_sof       <= (byte_cnt == '0);
                  state       <= StData;
               end
            end
            StData: begin
               if (accept) begin
                  o_sof <= 1'b0;
                  if (bit_cnt != '0) begin
                     bit_cnt <= nxt_idx;
                     o_sym   <= conv_sym(data_q[nxt_idx[BitW-2:0]], sr_nxt);
                  end else if (byte_cnt != LastByte) begin
                     byte_cnt    <= byte_cnt + 1'b1;
                     o_sym_valid <= 1'b0;
                     state       <= StReq;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     tail_cnt <= TailTop;
                     o_sym    <= conv_sym(1'b0, sr_nxt);
                     o_eof    <= (TailTop == '0);
                     state    <= StTail;
                  end
               end
            end
            StTail: begin
               if (accept) begin
                  if (tail_cnt == '0) begin
                     o_sym_valid <= 1'b0;
                     o_eof       <= 1'b0;
                     state       <= StIdle;
                  end else begin
                     tail_cnt <= tail_cnt - 1'b1;
                     o_sym    <= conv_sym(1'b0, sr_nxt);
                     o_eof    <= (tail_cnt == TailW'(1));
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
// Randomised bench for conv_encoder: fifo model, random backpressure and a direct
// convolution-sum reference model of each frame.
module tb_conv_encoder;

   localparam int unsigned DW    = 8;
   localparam int unsigned FB    = 4;
   localparam int unsigned NTAIL = 6;
   localparam int unsigned NSYM  = FB * DW + NTAIL;
   localparam logic [6:0]  POLY0 = 7'o171;
   localparam logic [6:0]  POLY1 = 7'o133;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       en        = 1'b0;
   logic       sym_ready = 1'b1;
   logic [7:0] fifo_data = '0;
   logic       fifo_dv   = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       rd_en;
   logic [1:0] sym;
   logic       sym_valid;
   logic       sof;
   logic       eof;
   logic       busy;

   conv_encoder #(
      .DATA_WIDTH  (DW),
      .FRAME_BYTES (FB)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_fifo_data  (fifo_data),
      .i_fifo_dv    (fifo_dv),
      .i_fifo_empty (fifo_empty),
      .o_fifo_rd_en (rd_en),
      .o_sym        (sym),
      .o_sym_valid  (sym_valid),
      .i_sym_ready  (sym_ready),
      .o_sof        (sof),
      .o_eof        (eof),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   logic [7:0] pend_q[$];
   logic [7:0] fifo_q[$];
   logic [7:0] sent_q[$];
   logic [3:0] got_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   bit         rnd_ready = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Fifo model: read data valid one cycle after rd_en; pushes land on the next edge.
   always @(posedge clk) begin
      fifo_dv <= 1'b0;
      if (rd_en && fifo_q.size() > 0) begin
         fifo_data <= fifo_q.pop_front();
         fifo_dv   <= 1'b1;
      end
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
   end

   always @(posedge clk) begin
      #2;
      sym_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   logic       prev_stall = 1'b0;
   logic       prev_rd    = 1'b0;
   logic [4:0] prev_out   = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
         prev_rd    <= 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", {sym_valid, sof, eof, sym}, prev_out);
         if (rd_en) begin
            check("rden_nonempty", fifo_empty, 0);
            check("rden_pulse", prev_rd, 0);
         end
         if (sym_valid && sym_ready) got_q.push_back({sof, eof, sym});
         prev_stall <= sym_valid && !sym_ready;
         prev_out   <= {sym_valid, sof, eof, sym};
         prev_rd    <= rd_en;
      end
   end

   task automatic push_byte(input logic [7:0] b);
      pend_q.push_back(b);
      sent_q.push_back(b);
   endtask

   task automatic wait_syms(input int n);
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         #1;
         if (got_q.size() >= n) break;
      end
   endtask

   // Reference: each output bit is the mod-2 sum of generator taps over the input history.
   task automatic check_frames(input string tag, input int nframes);
      logic [3:0] exp_q[$];
      logic       u[$];
      logic [6:0] g0;
      logic [6:0] g1;
      logic       c0;
      logic       c1;
      bit         done;
      g0 = POLY0;
      g1 = POLY1;
      for (int f = 0; f < nframes; f++) begin
         u.delete();
         for (int b = 0; b < FB; b++)
            for (int i = DW - 1; i >= 0; i--) u.push_back(sent_q[f * FB + b][i]);
         for (int t = 0; t < NTAIL; t++) u.push_back(1'b0);
         for (int n = 0; n < NSYM; n++) begin
            c0 = 1'b0;
            c1 = 1'b0;
            for (int j = 0; j < 7; j++) begin
               if (n >= j) begin
                  c0 = c0 ^ (g0[6-j] & u[n-j]);
                  c1 = c1 ^ (g1[6-j] & u[n-j]);
               end
            end
            exp_q.push_back({(n == 0), (n == NSYM - 1), c0, c1});
         end
      end
      done = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         #1;
         if (got_q.size() >= exp_q.size() && !busy) begin
            done = 1'b1;
            break;
         end
      end
      check($sformatf("%s_done", tag), done, 1);
      check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_sym%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic clear_logs();
      got_q.delete();
      sent_q.delete();
   endtask

   task automatic check_impulse(input string tag);
      logic [1:0] imp[14];
      imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11,
              2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 14 && i < got_q.size(); i++)
         check($sformatf("%s_gold%0d", tag, i), got_q[i][1:0], imp[i]);
   endtask

   initial begin
      int any_rd;
      repeat (2) @(negedge clk);
      check("rst_rd_en", rd_en, 0);
      check("rst_sym", sym, 0);
      check("rst_valid", sym_valid, 0);
      check("rst_sof", sof, 0);
      check("rst_eof", eof, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      en = 1'b1;
      any_rd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rd_en) any_rd++;
      end
      check("empty_rden", any_rd, 0);
      check("empty_busy", busy, 0);

      push_byte(8'h80);
      for (int i = 1; i < FB; i++) push_byte(8'h00);
      check_frames("impulse", 1);
      check_impulse("impulse");
      check("impulse_idle", busy, 0);
      clear_logs();

      // Second byte arrives late; encoder must park in REQ without reading.
      push_byte(8'h5A);
      wait_syms(8);
      repeat (10) @(negedge clk);
      check("midempty_busy", busy, 1);
      check("midempty_valid", sym_valid, 0);
      for (int i = 1; i < FB; i++) push_byte(8'($urandom_range(0, 255)));
      check_frames("midempty", 1);
      clear_logs();

      rnd_ready = 1'b1;
      push_byte(8'hA5);
      push_byte(8'h3C);
      push_byte(8'hFF);
      push_byte(8'h00);
      check_frames("bp", 1);
      clear_logs();
      rnd_ready = 1'b0;

      for (int i = 0; i < FB; i++) push_byte(8'($urandom_range(0, 255)));
      wait_syms(DW + 4);
      check("rstmid_reach", (got_q.size() >= DW + 4), 1);
      rst = 1'b1;
      #1;
      check("rstmid_rd_en", rd_en, 0);
      check("rstmid_sym", sym, 0);
      check("rstmid_valid", sym_valid, 0);
      check("rstmid_sof", sof, 0);
      check("rstmid_eof", eof, 0);
      check("rstmid_busy", busy, 0);
      pend_q.delete();
      fifo_q.delete();
      clear_logs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_byte(8'h80);
      for (int i = 1; i < FB; i++) push_byte(8'h00);
      check_frames("reimpulse", 1);
      check_impulse("reimpulse");
      clear_logs();

      // Dropping en mid-frame must still let the frame and its tail finish.
      for (int i = 0; i < FB; i++) push_byte(8'($urandom_range(0, 255)));
      wait_syms(3);
      en = 1'b0;
      check_frames("endrop", 1);
      clear_logs();
      for (int i = 0; i < FB; i++) push_byte(8'($urandom_range(0, 255)));
      repeat (20) @(negedge clk);
      check("endis_busy", busy, 0);
      en = 1'b1;
      check_frames("enresume", 1);
      clear_logs();

      for (int i = 0; i < 2 * FB; i++) push_byte(8'($urandom_range(0, 255)));
      check_frames("b2b", 2);
      clear_logs();

      rnd_ready = 1'b1;
      for (int i = 0; i < 3 * FB; i++) push_byte(8'($urandom_range(0, 255)));
      check_frames("rand", 3);
      clear_logs();
      rnd_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
